oreg_uart_tx: RTL and testbench
===============================

Name: oreg_uart_tx

Overview:
- Downstream consumer of the microprocessor's 4-bit o_reg output port.
- Detects every change of o_reg and queues the new nibble in a small FIFO.
- Serialises each queued nibble as one ASCII hex character on an 8N1 UART line, giving a host-visible trace of program output.
- Sits beside the microprocessor top level and shares its clock.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal values are 2 or more.
- FIFO_DEPTH, 8, number of nibble entries; must be a power of 2, 2 or more.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- o_reg  input  4  microprocessor output register.
- capture_en  input  1  1 = pushes on o_reg change are allowed.
- clear_overflow  input  1  1-cycle pulse that clears overflow.
- tx  output  1  UART serial out; idle level is 1.
- busy  output  1  1 while the FIFO is non-empty or a frame is in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued entries.
- overflow  output  1  sticky; set when a push is dropped because the FIFO is full.

Behaviour:
- Reset (reset=0 at a clk edge):
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - prev_q=0, FSM to IDLE, bit and baud counters to 0.
  - Takes effect mid-frame: tx returns to 1 on that same edge and queued data is discarded.
- Change detect:
  - prev_q loads o_reg every cycle, independent of capture_en.
  - Push condition: o_reg != prev_q and capture_en=1.
  - No push in the first cycle after reset release unless o_reg != 0.
  - Consecutive changes push once per cycle.
- FIFO:
  - Circular buffer; read and write pointers wrap at FIFO_DEPTH.
  - Push while full with no pop in the same cycle: data dropped, overflow set to 1.
  - Push and pop in the same cycle: both take effect, including when full, so fifo_count is unchanged.
  - clear_overflow clears overflow. If clear_overflow and a new drop occur in the same cycle, overflow stays 1.
- Encoding: nibble 0x0–0x9 maps to 0x30–0x39; nibble 0xA–0xF maps to 0x41–0x46.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if fifo_count>0, pop the head, latch its ASCII byte and go to START. tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=byte[bit], LSB first, CLKS_PER_BIT cycles per bit, 8 bits, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - tx falls on the edge after the pop cycle.
  - A frame is exactly 10*CLKS_PER_BIT cycles of START+DATA+STOP.
  - Back-to-back frames are separated by exactly 1 IDLE cycle.
- busy = (state != IDLE) or (fifo_count != 0). It is registered and consistent with the same-cycle state and count.
- o_reg changes during a frame are queued; they never disturb the frame in progress.

Optional Feature:
- Macro OREG_TX_NEWLINE_EN.
- Defined:
  - After each hex character's STOP, the FSM sends a second frame with byte 0x0A (LF) before returning to IDLE.
  - The two frames are separated by 1 idle cycle.
  - One entry now costs 20*CLKS_PER_BIT+1 cycles.
  - Reset during the LF frame behaves as reset mid-frame.
- Undefined: single-character frames only; no LF logic is present.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single change: reset release, capture_en=1, o_reg 0→5 → one frame with byte 0x35; tx bit sequence 0,1,0,1,0,1,1,0,0,1, each bit 4 cycles; busy falls 1 cycle after STOP ends.
- Hex letter and gating:
  - o_reg→0xC with capture_en=1 → byte 0x43.
  - o_reg→0x3 with capture_en=0 → no frame; a later change 0x3→0x3 produces nothing.
- Overflow: 6 distinct o_reg values on consecutive cycles while the first frame is in progress → fifo_count saturates at 4 with 1 entry in flight; at least one push is dropped; overflow=1 until a clear_overflow pulse; sent characters are the first accepted values in order.
- Wrap-around: 10 changes spaced so the FIFO never fills → all 10 characters received in order; pointers wrap twice without loss.
- Reset mid-frame: assert reset=0 during DATA bit 3 → tx=1 on that edge, fifo_count=0, no further frames after release with o_reg held constant.
- Newline option (OREG_TX_NEWLINE_EN defined): o_reg 0→A → frames 0x41 then 0x0A, 1 idle cycle apart, total 81 cycles from pop to IDLE.

Source files
------------

// File: rtl/oreg_uart_tx.sv
// Watches the 4-bit o_reg port, queues each new value and sends it as one ASCII hex character on an 8N1 UART line.
// Defining OREG_TX_NEWLINE_EN appends an LF frame after every hex character.
module oreg_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    o_reg,
    input  logic                          capture_en,
    input  logic                          clear_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

`ifdef OREG_TX_NEWLINE_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LF_GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state;
    logic [3:0]     prev_q;
    logic [3:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [7:0]     tx_byte;
`ifdef OREG_TX_NEWLINE_EN
    logic           is_lf;
`endif

    logic           push_req;
    logic           push_ok;
    logic           pop;
    logic           full;
    logic           drop;
    logic           baud_last;
    logic           idle_next;
    logic [AW:0]    count_next;
    logic [3:0]     head;
    logic [7:0]     ascii;

    always_comb begin
        push_req   = capture_en && (o_reg != prev_q);
        pop        = (state == IDLE) && (fifo_count != '0);
        full       = (fifo_count == FULL_COUNT);
        push_ok    = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        count_next = fifo_count;
        if (push_ok && !pop) begin
            count_next = fifo_count + (AW+1)'(1);
        end else if (!push_ok && pop) begin
            count_next = fifo_count - (AW+1)'(1);
        end
        baud_last = (baud == BAUD_LAST);
        idle_next = (state == IDLE) && !pop;
`ifdef OREG_TX_NEWLINE_EN
        if ((state == STOP) && baud_last && is_lf) begin
            idle_next = 1'b1;
        end
`else
        if ((state == STOP) && baud_last) begin
            idle_next = 1'b1;
        end
`endif
        head  = mem[rd_ptr];
        ascii = (head < 4'd10) ? (8'h30 + {4'h0, head}) : (8'h37 + {4'h0, head});
    end

    // Storage is not reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= o_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q     <= 4'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_q <= o_reg;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_next;
            // A drop in the same cycle as a clear wins so no lost data goes unreported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_idx <= 3'd0;
            tx_byte <= 8'h00;
`ifdef OREG_TX_NEWLINE_EN
            is_lf   <= 1'b0;
`endif
        end else begin
            busy <= !(idle_next && (count_next == '0));
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        tx_byte <= ascii;
                        baud    <= '0;
                        tx      <= 1'b0;
                        state   <= START;
`ifdef OREG_TX_NEWLINE_EN
                        is_lf   <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        tx      <= tx_byte[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Shift so the next bit to send always sits at tx_byte[1].
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= tx_byte[1];
                            tx_byte <= {1'b0, tx_byte[7:1]};
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
`ifdef OREG_TX_NEWLINE_EN
                        state <= is_lf ? IDLE : LF_GAP;
`else
                        state <= IDLE;
`endif
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`ifdef OREG_TX_NEWLINE_EN
                LF_GAP: begin
                    tx_byte <= 8'h0A;
                    is_lf   <= 1'b1;
                    baud    <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end
`endif
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oreg_uart_tx.sv
// Directed bench for oreg_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a UART monitor checks received characters against an expected queue.
module tb_oreg_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef OREG_TX_NEWLINE_EN
    localparam bit NL = 1'b1;
`else
    localparam bit NL = 1'b0;
`endif
    localparam int POP2   = NL ? 83 : 42;
    localparam int SPACE  = NL ? 90 : 45;
    localparam int BUSY_N = NL ? 82 : 41;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] o_reg;
    logic       capture_en;
    logic       clear_overflow;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    bit         mon_en;
    string      hex_chars = "0123456789ABCDEF";
    logic [3:0] ovf_vals [6]  = '{4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'h8};
    logic [3:0] wrap_vals [10] = '{4'hF, 4'h0, 4'h9, 4'hB, 4'hD, 4'hE, 4'h2, 4'h5, 4'hA, 4'h3};
    logic [9:0] frame;
    int         busy_cycles;
    int         low_cycles;

    oreg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .o_reg(o_reg),
        .capture_en(capture_en),
        .clear_overflow(clear_overflow),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_char(input logic [3:0] nib);
        exp_q.push_back(8'(hex_chars[nib]));
        if (NL) exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < 2000) begin
            next_cycle();
            i++;
        end
        check({tag, "_idle"}, busy, 0);
        next_cycle(3);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // UART receiver: samples near the middle of each bit on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                logic [7:0] b;
                next_cycle(5);
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx;
                    if (i < 7) next_cycle(4);
                end
                next_cycle(4);
                if (mon_en) begin
                    check("stop_bit", tx, 1);
                    if (exp_q.size() == 0) check("rx_unexpected", exp_q.size(), 1);
                    else check("rx_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        o_reg = 4'h0;
        capture_en = 1'b1;
        clear_overflow = 1'b0;
        mon_en = 1'b1;
        next_cycle(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);

        reset = 1'b1;
        next_cycle();
        check("release_count", fifo_count, 0);
        check("release_busy", busy, 0);

        // Single change 0 -> 5: frame for 0x35 checked cycle by cycle.
        o_reg = 4'h5;
        expect_char(4'h5);
        frame = {1'b1, 8'h35, 1'b0};
        next_cycle();
        check("t1_count", fifo_count, 1);
        check("t1_busy", busy, 1);
        check("t1_tx_idle", tx, 1);
        next_cycle();
        for (int i = 0; i < 40; i++) begin
            check("t1_bit", tx, frame[i/4]);
            if (i == 39) check("t1_busy_stop", busy, 1);
            next_cycle();
        end
        check("t1_busy_end", busy, {31'b0, NL});
        check("t1_tx_end", tx, 1);
        wait_idle("t1");

        // Hex letter, plus busy length from push to idle.
        o_reg = 4'hC;
        expect_char(4'hC);
        next_cycle();
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 500) begin
            busy_cycles++;
            next_cycle();
        end
        check("t2_busy_len", busy_cycles, BUSY_N);
        wait_idle("t2");

        // Gating: change while disabled is not queued and not replayed later.
        capture_en = 1'b0;
        o_reg = 4'h3;
        next_cycle(3);
        check("gate_count", fifo_count, 0);
        check("gate_busy", busy, 0);
        capture_en = 1'b1;
        next_cycle(5);
        check("gate_count_after", fifo_count, 0);
        check("gate_busy_after", busy, 0);
        check("gate_tx", tx, 1);

        // Overflow: six back-to-back changes, last one dropped.
        for (int k = 0; k < 6; k++) begin
            o_reg = ovf_vals[k];
            if (k < 5) expect_char(ovf_vals[k]);
            next_cycle();
        end
        check("ovf_count_full", fifo_count, 4);
        check("ovf_set", overflow, 1);
        o_reg = 4'h9;
        clear_overflow = 1'b1;
        next_cycle();
        check("ovf_clear_vs_drop", overflow, 1);
        check("ovf_count_hold", fifo_count, 4);
        next_cycle();
        check("ovf_cleared", overflow, 0);
        clear_overflow = 1'b0;
        next_cycle(POP2 - 8);
        check("full_before_pop", fifo_count, 4);
        o_reg = 4'hA;
        expect_char(4'hA);
        next_cycle();
        check("full_push_pop", fifo_count, 4);
        check("full_push_pop_ovf", overflow, 0);
        wait_idle("t3");

        // Wrap-around: ten spaced changes.
        for (int k = 0; k < 10; k++) begin
            o_reg = wrap_vals[k];
            expect_char(wrap_vals[k]);
            next_cycle(SPACE);
        end
        check("t4_no_ovf", overflow, 0);
        wait_idle("t4");

        // Reset during DATA bit 3 of 0x37 with one more entry queued.
        mon_en = 1'b0;
        o_reg = 4'h7;
        next_cycle(3);
        o_reg = 4'h8;
        next_cycle(16);
        check("t5_count_before", fifo_count, 1);
        check("t5_tx_bit3", tx, 0);
        reset = 1'b0;
        o_reg = 4'h0;
        next_cycle();
        check("t5_tx_reset", tx, 1);
        check("t5_count_reset", fifo_count, 0);
        check("t5_busy_reset", busy, 0);
        next_cycle(2);
        reset = 1'b1;
        low_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            next_cycle();
            if (tx !== 1'b1) low_cycles++;
        end
        check("t5_quiet", low_cycles, 0);
        check("t5_busy_after", busy, 0);
        check("t5_count_after", fifo_count, 0);
        mon_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
